// File: rtl/tft_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tft_bus_arbiter_pkg
// Description : Shared state encoding and TFT command bytes for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tft_bus_arbiter_pkg;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GRANT = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    // Command bytes already emitted by the drawing blocks
    localparam logic [7:0] c_CMD_CASET = 8'h2a;
    localparam logic [7:0] c_CMD_PASET = 8'h2b;
    localparam logic [7:0] c_CMD_RAMWR = 8'h2c;

endpackage
`default_nettype wire

// File: rtl/tft_bus_arbiter_rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_select
// Description : Picks the first set request bit at or above rr_ptr, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_select #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               any
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;

    // Scan highest offset first so the lowest offset from rr_ptr wins last
    always_comb begin
        winner = '0;
        w_sum  = '0;
        w_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (req[w_idx]) begin
                winner = w_idx;
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/tft_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tft_bus_arbiter
// Description : Round-robin owner of the shared TFT byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tft_bus_arbiter
    import tft_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_dc,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_transmit,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   req_tft_busy,
    output logic                 tft_dc,
    output logic [7:0]           tft_data,
    output logic                 tft_transmit,
    input  logic                 tft_busy,
    output logic [PTR_W-1:0]     owner,
    output logic                 bus_active
);

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_winner;
    logic               w_any;
    logic [7:0]         w_data;
    logic               w_dc;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_select (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_grant <= NUM_REQ'(1) << w_winner;
                        r_owner <= w_winner;
                        r_state <= c_GRANT;
                    end
                end
                c_GRANT: begin
                    if (!req[r_owner]) begin
                        r_grant <= '0;
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    // Hand over only once the last byte has fully shifted out
                    if (!tft_busy && !tft_transmit) begin
                        r_rr_ptr <= (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
                        r_state  <= c_IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_data = '0;
        w_dc   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_data = req_data[8*i +: 8];
                w_dc   = req_dc[i];
            end
        end
    end

    assign grant        = r_grant;
    assign owner        = r_owner;
    assign bus_active   = (r_state != c_IDLE);
    assign tft_transmit = |(req_transmit & r_grant);
    assign tft_data     = w_data;
    assign tft_dc       = w_dc;
    // Everyone but the owner sees a permanently busy driver
    assign req_tft_busy = ~r_grant | {NUM_REQ{tft_busy}};

endmodule
`default_nettype wire

// File: tb/tb_tft_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tft_bus_arbiter
// Description : Directed vector bench for tft_bus_arbiter (3 and 5 requesters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tft_bus_arbiter;
    import tft_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  req_dc = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  req_transmit = '0;
    logic [2:0]  grant;
    logic [2:0]  req_tft_busy;
    logic        tft_dc;
    logic [7:0]  tft_data;
    logic        tft_transmit;
    logic        tft_busy;
    logic [1:0]  owner;
    logic        bus_active;

    logic [4:0]  req5 = '0;
    logic [4:0]  grant5;
    logic [4:0]  req_tft_busy5;
    logic        tft_dc5;
    logic [7:0]  tft_data5;
    logic        tft_transmit5;
    logic [2:0]  owner5;
    logic        bus_active5;

    logic        tb_busy = 1'b0;
    logic        drv_en = 1'b0;
    logic [4:0]  drv_cnt;
    int          tx_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tft_bus_arbiter #(.NUM_REQ(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_dc       (req_dc),
        .req_data     (req_data),
        .req_transmit (req_transmit),
        .grant        (grant),
        .req_tft_busy (req_tft_busy),
        .tft_dc       (tft_dc),
        .tft_data     (tft_data),
        .tft_transmit (tft_transmit),
        .tft_busy     (tft_busy),
        .owner        (owner),
        .bus_active   (bus_active)
    );

    tft_bus_arbiter #(.NUM_REQ(5)) dut5 (
        .clk          (clk),
        .rst          (rst),
        .req          (req5),
        .req_dc       (5'b0),
        .req_data     (40'h0),
        .req_transmit (5'b0),
        .grant        (grant5),
        .req_tft_busy (req_tft_busy5),
        .tft_dc       (tft_dc5),
        .tft_data     (tft_data5),
        .tft_transmit (tft_transmit5),
        .tft_busy     (1'b0),
        .owner        (owner5),
        .bus_active   (bus_active5)
    );

    // Simple driver model: each accepted strobe keeps busy high for 16 cycles
    always @(posedge clk or posedge rst) begin
        if (rst)
            drv_cnt <= '0;
        else if (drv_en && tft_transmit)
            drv_cnt <= 5'd16;
        else if (drv_cnt != 0)
            drv_cnt <= drv_cnt - 1'b1;
    end
    assign tft_busy = drv_en ? (drv_cnt != 0) : tb_busy;

    always @(posedge clk or posedge rst) begin
        if (rst)
            tx_count <= 0;
        else if (tft_transmit)
            tx_count <= tx_count + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [23:0] data;
        logic [2:0]  trans;
        logic        busy;
        logic [2:0]  e_grant;
        logic [1:0]  e_owner;
        logic        e_active;
        logic        e_tx;
        logic        e_dc;
        logic [7:0]  e_data;
        logic [2:0]  e_rtb;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [23:0] d;
        logic [2:0]  rr_order[4];
        int          n;
        int          base;

        d = {c_CMD_RAMWR, c_CMD_CASET, 8'h11};
        //          req     data             trans   bsy  grant   own   act   tx    dc    data   rtb
        vecs[0]  = '{3'b000, d,               3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b111};
        vecs[1]  = '{3'b010, d,               3'b000, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0, 1'b0, 8'h2a, 3'b101};
        vecs[2]  = '{3'b010, d,               3'b110, 1'b0, 3'b010, 2'd1, 1'b1, 1'b1, 1'b0, 8'h2a, 3'b101};
        vecs[3]  = '{3'b010, d,               3'b000, 1'b1, 3'b010, 2'd1, 1'b1, 1'b0, 1'b0, 8'h2a, 3'b111};
        vecs[4]  = '{3'b000, d,               3'b000, 1'b1, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 3'b111};
        vecs[5]  = '{3'b101, d,               3'b000, 1'b1, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 3'b111};
        vecs[6]  = '{3'b101, d,               3'b000, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00, 3'b111};
        vecs[7]  = '{3'b101, d,               3'b000, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0, 1'b1, 8'h2c, 3'b011};
        vecs[8]  = '{3'b101, d,               3'b001, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0, 1'b1, 8'h2c, 3'b011};
        vecs[9]  = '{3'b001, d,               3'b000, 1'b0, 3'b000, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 3'b111};
        vecs[10] = '{3'b001, d,               3'b000, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 3'b111};
        vecs[11] = '{3'b001, d,               3'b000, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0, 1'b1, 8'h11, 3'b110};
        vecs[12] = '{3'b001, 24'hff2a11,      3'b100, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0, 1'b1, 8'h11, 3'b110};
        vecs[13] = '{3'b000, d,               3'b000, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'b111};
        vecs[14] = '{3'b000, d,               3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b111};

        req_dc = 3'b101;

        // Reset state
        tick();
        tick();
        chk("rst grant", grant, 3'b000);
        chk("rst owner", owner, 2'd0);
        chk("rst active", bus_active, 1'b0);
        chk("rst rtb", req_tft_busy, 3'b111);
        chk("rst data", tft_data, 8'h00);
        chk("rst tx", tft_transmit, 1'b0);
        #2 rst = 1'b0;

        foreach (vecs[i]) begin
            req          = vecs[i].req;
            req_data     = vecs[i].data;
            req_transmit = vecs[i].trans;
            tb_busy      = vecs[i].busy;
            tick();
            chk($sformatf("vec%0d grant", i), grant, vecs[i].e_grant);
            chk($sformatf("vec%0d owner", i), owner, vecs[i].e_owner);
            chk($sformatf("vec%0d active", i), bus_active, vecs[i].e_active);
            chk($sformatf("vec%0d tx", i), tft_transmit, vecs[i].e_tx);
            chk($sformatf("vec%0d dc", i), tft_dc, vecs[i].e_dc);
            chk($sformatf("vec%0d data", i), tft_data, vecs[i].e_data);
            chk($sformatf("vec%0d rtb", i), req_tft_busy, vecs[i].e_rtb);
        end
        req_transmit = '0;
        req_data = d;

        // Round robin with all three requesting; pointer restarts from reset
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        rr_order = '{3'b001, 3'b010, 3'b100, 3'b001};
        req = 3'b111;
        tick();
        chk("rr grant0", grant, rr_order[0]);
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 4; b++) begin
                req_transmit = grant;
                #1 chk($sformatf("rr%0d byte%0d tx", g, b), tft_transmit, 1'b1);
                tick();
                req_transmit = '0;
                tick();
            end
            if (g == 3) break;
            req = 3'b111 & ~grant;
            tick();
            req = 3'b111;
            n = 0;
            while (grant == 3'b000 && n < 10) begin
                n++;
                tick();
            end
            chk($sformatf("rr gap%0d", g), n, 2);
            chk($sformatf("rr grant%0d", g + 1), grant, rr_order[g + 1]);
        end
        req = 3'b000;
        tick();
        tick();

        // Strobe and drop in the same cycle, driver busy for 16 cycles
        drv_en = 1'b1;
        req = 3'b001;
        tick();
        chk("drain grant", grant, 3'b001);
        req_transmit = 3'b001;
        req = 3'b000;
        #1 chk("drain tx", tft_transmit, 1'b1);
        base = tx_count;
        tick();
        req_transmit = 3'b000;
        req = 3'b001;
        n = 0;
        while (bus_active && grant == 3'b000 && n < 40) begin
            n++;
            tick();
        end
        chk("drain len", n, 17);
        chk("drain tx count", tx_count - base, 1);
        tick();
        chk("single regrant", grant, 3'b001);
        req = 3'b000;
        tick();
        tick();
        drv_en = 1'b0;

        // Move pointer to 2, then reset asynchronously mid-GRANT
        req = 3'b010;
        tick();
        req = 3'b000;
        tick();
        tick();
        req = 3'b001;
        tick();
        chk("pre-rst grant", grant, 3'b001);
        req_transmit = 3'b001;
        #1 chk("pre-rst tx", tft_transmit, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("async rst grant", grant, 3'b000);
        chk("async rst tx", tft_transmit, 1'b0);
        chk("async rst active", bus_active, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        req_transmit = 3'b000;
        req = 3'b110;
        tick();
        chk("post-rst ptr0 grant", grant, 3'b010);
        req = 3'b000;
        tick();
        tick();

        // Five requesters: pointer wraps from 4 back to 0
        req5 = 5'b10000;
        tick();
        chk("n5 grant4", grant5, 5'b10000);
        chk("n5 owner4", owner5, 3'd4);
        req5 = 5'b00000;
        tick();
        tick();
        req5 = 5'b10001;
        tick();
        chk("n5 wrap grant", grant5, 5'b00001);
        chk("n5 wrap owner", owner5, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
